// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared constants and types for the 1-to-8 demux scheduler
package demux_sched_pkg;
  localparam int NLANES = 8;
  localparam int SELW = 3;
  localparam logic MODE_RR = 1'b0;
  localparam logic MODE_DIR = 1'b1;
  localparam logic [7:0] DROP_MAX = 8'd255;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/demux_rr_scheduler_rr_pick8.sv
// rr_pick8: cyclic priority finder returning the first set mask bit at or after start
module rr_pick8 (
  input  logic [7:0] mask,
  input  logic [2:0] start,
  output logic [2:0] idx,
  output logic       found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[3'(int'(start) + i)]) begin
        idx = 3'(int'(start) + i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: one-entry holding stage steering words to 8 lanes by round-robin or directed select
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SELW-1:0]   in_sel,
  input  logic [NLANES-1:0] lane_en,
  output logic [NLANES-1:0] out_valid,
  input  logic [NLANES-1:0] out_ready,
  output logic [DW-1:0]     out_data,
  output logic [SELW-1:0]   sel,
  output logic              drop,
  output logic [7:0]        drop_cnt
);
  state_t state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d, rr_idx;
  logic drop_q, drop_d, rr_found, complete, accept, store, dropped, dir;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  rr_pick8 u_pick (
    .mask  (lane_en),
    .start (ptr_q),
    .idx   (rr_idx),
    .found (rr_found)
  );
  assign dir = (mode == MODE_DIR);
  assign complete = (state_q == FULL) && out_ready[sel_q];
  assign in_ready = rst_n && (state_q == EMPTY || complete) && (dir || |lane_en);
  assign accept = in_valid && in_ready;
  assign store = accept && (dir ? lane_en[in_sel] : rr_found);
  assign dropped = accept && dir && !lane_en[in_sel];
  always_comb begin
    state_d = store ? FULL : complete ? EMPTY : state_q;
    data_d = store ? in_data : data_q;
    sel_d = store ? (dir ? in_sel : rr_idx) : sel_q;
    ptr_d = (store && !dir) ? rr_idx + 3'd1 : ptr_q;
    drop_d = dropped;
    drop_cnt_d = (dropped && drop_cnt_q != DROP_MAX) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      drop_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      drop_q <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign out_valid = (rst_n && state_q == FULL) ? {{(NLANES-1){1'b0}}, 1'b1} << sel_q : '0;
  assign out_data = data_q;
  assign sel = sel_q;
  assign drop = drop_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb_demux_rr_scheduler: table-driven directed check of the demux scheduler
module tb_demux_rr_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, in_valid = 1'b0, in_ready, drop;
  logic [7:0] in_data = '0, lane_en = 8'hFF, out_valid, out_ready = 8'hFF, out_data, drop_cnt;
  logic [2:0] in_sel = '0, sel;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  demux_rr_scheduler #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .lane_en(lane_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sel(sel), .drop(drop), .drop_cnt(drop_cnt)
  );
  typedef struct {
    logic r, m, v;
    logic [7:0] d;
    logic [2:0] s;
    logic [7:0] le, ordy;
    logic e_rdy;
    logic [7:0] e_ov;
    logic sd;
    logic [2:0] e_sel;
    logic [7:0] e_dat;
    logic e_drop;
    logic [7:0] e_cnt;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(input logic r, m, v, input logic [7:0] d, input logic [2:0] s,
                              input logic [7:0] le, ordy, input logic e_rdy, input logic [7:0] e_ov,
                              input logic sd, input logic [2:0] e_sel, input logic [7:0] e_dat,
                              input logic e_drop, input logic [7:0] e_cnt);
    vec_t t;
    t.r = r; t.m = m; t.v = v; t.d = d; t.s = s; t.le = le; t.ordy = ordy;
    t.e_rdy = e_rdy; t.e_ov = e_ov; t.sd = sd; t.e_sel = e_sel; t.e_dat = e_dat;
    t.e_drop = e_drop; t.e_cnt = e_cnt;
    return t;
  endfunction
  task automatic apply(input vec_t t, input int idx);
    logic ok;
    @(negedge clk);
    rst_n = t.r; mode = t.m; in_valid = t.v; in_data = t.d; in_sel = t.s;
    lane_en = t.le; out_ready = t.ordy;
    #1;
    ok = (in_ready === t.e_rdy) && (out_valid === t.e_ov) && (drop === t.e_drop) &&
         (drop_cnt === t.e_cnt) && (!t.sd || (sel === t.e_sel && out_data === t.e_dat));
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: in_ready=%b/%b out_valid=%h/%h sel=%0d/%0d data=%h/%h drop=%b/%b cnt=%0d/%0d (got/exp)",
               idx, in_ready, t.e_rdy, out_valid, t.e_ov, sel, t.e_sel, out_data, t.e_dat,
               drop, t.e_drop, drop_cnt, t.e_cnt);
    end
  endtask
  initial begin
    int lanes[4] = '{2, 5, 7, 2};
    tv.push_back(mk(0,0,0,8'h00,0,8'hFF,8'hFF, 0,8'h00,0,0,8'h00,0,8'd0));
    for (int k = 0; k < 10; k++)
      tv.push_back(mk(1,0,1,8'(k),0,8'hFF,8'hFF, 1, k > 0 ? 8'(1) << ((k+7)%8) : 8'h00,
                      k > 0, 3'((k+7)%8), 8'(k-1), 0, 8'd0));
    tv.push_back(mk(1,0,0,8'h00,0,8'hFF,8'hFF, 1,8'h02,1,1,8'h09,0,8'd0));
    tv.push_back(mk(1,0,0,8'h00,0,8'hFF,8'hFF, 1,8'h00,1,1,8'h09,0,8'd0));
    tv.push_back(mk(0,0,0,8'h00,0,8'hFF,8'hFF, 0,8'h00,0,0,8'h00,0,8'd0));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(1,0,1,8'(8'h10+k),0,8'hA4,8'hFF, 1, k > 0 ? 8'(1) << lanes[(k+3)%4] : 8'h00,
                      k > 0, 3'(lanes[(k+3)%4]), 8'(8'h10+k-1), 0, 8'd0));
    tv.push_back(mk(1,0,0,8'h00,0,8'hA4,8'hFF, 1,8'h04,1,2,8'h13,0,8'd0));
    tv.push_back(mk(1,0,0,8'h00,0,8'hA4,8'hFF, 1,8'h00,0,0,8'h00,0,8'd0));
    for (int k = 0; k < 5; k++)
      tv.push_back(mk(1,0,1,8'h20,0,8'h00,8'hFF, 0,8'h00,0,0,8'h00,0,8'd0));
    tv.push_back(mk(1,0,1,8'h20,0,8'h08,8'hFF, 1,8'h00,0,0,8'h00,0,8'd0));
    tv.push_back(mk(1,0,0,8'h00,0,8'h08,8'hFF, 1,8'h08,1,3,8'h20,0,8'd0));
    tv.push_back(mk(1,0,0,8'h00,0,8'h08,8'hFF, 1,8'h00,0,0,8'h00,0,8'd0));
    tv.push_back(mk(1,1,1,8'h30,6,8'h40,8'hBF, 1,8'h00,0,0,8'h00,0,8'd0));
    tv.push_back(mk(1,1,1,8'h31,1,8'hFF,8'hBF, 0,8'h40,1,6,8'h30,0,8'd0));
    tv.push_back(mk(1,1,1,8'h31,2,8'h00,8'hBF, 0,8'h40,1,6,8'h30,0,8'd0));
    tv.push_back(mk(1,0,1,8'h31,3,8'h00,8'hBF, 0,8'h40,1,6,8'h30,0,8'd0));
    tv.push_back(mk(1,1,1,8'h31,6,8'h0F,8'hBF, 0,8'h40,1,6,8'h30,0,8'd0));
    tv.push_back(mk(1,1,1,8'h31,6,8'h40,8'hFF, 1,8'h40,1,6,8'h30,0,8'd0));
    tv.push_back(mk(1,1,0,8'h00,6,8'h40,8'hFF, 1,8'h40,1,6,8'h31,0,8'd0));
    tv.push_back(mk(1,1,0,8'h00,6,8'h40,8'hFF, 1,8'h00,0,0,8'h00,0,8'd0));
    for (int k = 0; k < 300; k++)
      tv.push_back(mk(1,1,1,8'(k),3,8'hF7,8'hFF, 1,8'h00,0,0,8'h00, k > 0, k > 255 ? 8'd255 : 8'(k)));
    tv.push_back(mk(1,1,0,8'h00,3,8'hF7,8'hFF, 1,8'h00,0,0,8'h00,1,8'd255));
    tv.push_back(mk(1,1,0,8'h00,3,8'hF7,8'hFF, 1,8'h00,0,0,8'h00,0,8'd255));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);
    apply(mk(1,1,1,8'h55,4,8'hFF,8'h00, 1,8'h00,0,0,8'h00,0,8'd255), 1000);
    apply(mk(1,1,0,8'h00,4,8'hFF,8'hEF, 0,8'h10,1,4,8'h55,0,8'd255), 1001);
    apply(mk(0,1,0,8'h00,4,8'hFF,8'hFF, 0,8'h00,0,0,8'h00,0,8'd255), 1002);
    apply(mk(1,0,0,8'h00,0,8'hFF,8'hFF, 1,8'h00,1,0,8'h00,0,8'd0), 1003);
    apply(mk(1,0,1,8'h66,0,8'hFF,8'hFF, 1,8'h00,1,0,8'h00,0,8'd0), 1004);
    apply(mk(1,0,0,8'h00,0,8'hFF,8'hFF, 1,8'h01,1,0,8'h66,0,8'd0), 1005);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
- Sequencing controller for the 1-to-8 lane demultiplexer path: accepts a single input word stream (valid/ready) and steers each word to exactly one of 8 output lanes.
- Lane chosen by round-robin over enabled lanes (mode 0) or by a per-word directed select (mode 1).
- One-entry holding register decouples input from lane back-pressure. Sits between the upstream source and the 1-to-8 demux fabric and drives its select and enables.

Parameters:
DW, 8, data word width
NLANES, 8, number of output lanes (fixed at 8; SELW = 3 derived)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
mode  input  1  0 = round-robin, 1 = directed
in_valid  input  1  input word present
in_ready  output  1  input word accepted when in_valid & in_ready
in_data  input  DW  input word
in_sel  input  3  target lane in directed mode
lane_en  input  8  per-lane enable mask
out_valid  output  8  one-hot lane valid (at most one bit set)
out_ready  input  8  per-lane ready
out_data  output  DW  held word, broadcast to all lanes
sel  output  3  lane index of held word (demux select)
drop  output  1  one-cycle pulse: directed word discarded
drop_cnt  output  8  saturating count of dropped words

Behaviour:
- Reset (rst_n low at clk edge):
  - out_valid = 0, out_data = 0, sel = 0, rr pointer = 0, drop = 0, drop_cnt = 0, state = EMPTY.
  - in_ready is forced 0 while rst_n is low.
- States:
  - EMPTY: no held word, out_valid = 0.
  - FULL: held word, out_valid[sel] = 1.
- complete = FULL & out_ready[sel].
- in_ready (combinational) = rst_n & (EMPTY | complete) & (mode | (|lane_en)).
  - Round-robin mode with lane_en = 0 stalls the input; nothing is dropped.
- Accept (in_valid & in_ready):
  - mode 0: lane = first i with lane_en[i] = 1, searching cyclically from the pointer (pointer, pointer+1, ... wrapping 7 to 0). The word and lane are registered, state becomes FULL, and the pointer becomes lane+1 (mod 8).
  - mode 1 with lane_en[in_sel] = 1: the word and in_sel are registered, state becomes FULL. Pointer unchanged.
  - mode 1 with lane_en[in_sel] = 0: the word is consumed but not stored. drop = 1 in the next cycle only, drop_cnt increments and saturates at 255. State follows the complete rule only.
- Latency: a word accepted at edge N has out_valid asserted in the cycle after edge N.
- complete & no accept: state becomes EMPTY and out_valid clears at the next edge.
- complete & accept of a stored word in the same cycle: back-to-back transfer. State stays FULL; out_data, sel and out_valid load the new word, giving full throughput of one word per cycle.
- Held word is sticky:
  - Changes to lane_en, mode or in_sel while FULL do not alter sel, out_data or out_valid.
  - A held word waits indefinitely for out_ready[sel]; out_ready on other lanes is ignored.
- out_data and sel hold their last value when EMPTY (no zeroing).
- Reset mid-transfer discards the held word; no output handshake completes in that cycle.

Decomposition:
- Package demux_sched_pkg holds:
  - NLANES = 8 and SELW = 3
  - mode encoding MODE_RR = 0, MODE_DIR = 1
  - state enum {EMPTY, FULL}
  - DROP_MAX = 255
- One sub-module, rr_pick8: combinational cyclic priority finder with inputs (mask[7:0], start[2:0]) and outputs (idx[2:0], found). Unit-tested standalone.

Test Plan:
- Reset, then mode 0, lane_en = 8'hFF, all out_ready = 1, 10 back-to-back words 0x00..0x09 -> lanes 0,1,...,7,0,1 in consecutive cycles; in_ready stays 1 throughout; first out_valid appears 1 cycle after the first accept.
- mode 0, lane_en = 8'b1010_0100, pointer 0, 4 words -> lanes 2,5,7,2.
- mode 0, lane_en = 0, in_valid = 1 -> in_ready = 0 and out_valid = 0 for 5 cycles; after lane_en = 8'h08 -> word goes to lane 3.
- mode 1, in_sel = 6, lane_en[6] = 1, out_ready[6] = 0 for 4 cycles -> out_valid = 8'h40 held, in_ready = 0 and out_data stable; lane_en and in_sel toggled during the stall have no effect; when out_ready[6] = 1 the word completes and a new word is accepted in the same cycle.
- mode 1, in_sel = 3, lane_en[3] = 0, 300 words -> 300 single-cycle drop pulses, drop_cnt = 255 (saturated), out_valid always 0.
- Held word in lane 4, rst_n low for 1 cycle -> next cycle out_valid = 0, sel = 0, drop_cnt = 0, pointer = 0; the next mode 0 word with lane_en = 8'hFF goes to lane 0.
